// File: rtl/team_06_noise_gate_if.sv
// Sample-stream bundle between the audio source and the noise gate.
// The master drives the samples and the enable. The slave returns the gated stream.
interface team_06_noise_gate_if;
   logic       samp_valid;
   logic [7:0] mic_aud;
   logic       gate_en;
   logic [7:0] gate_aud;
   logic       gate_valid;
   logic       gate_open;

   modport master (
      output samp_valid, mic_aud, gate_en,
      input  gate_aud, gate_valid, gate_open
   );

   modport slave (
      input  samp_valid, mic_aud, gate_en,
      output gate_aud, gate_valid, gate_open
   );
endinterface

// File: rtl/team_06_noise_gate.sv
// Hysteretic noise gate with hold window on 8-bit offset-binary audio; TEAM_06_NG_FADE_EN adds a gain ramp.
// Latency: one clk from samp_valid to gate_valid/gate_aud.
// Backpressure: none; every strobe is accepted, and idle cycles hold all state and outputs.
module team_06_noise_gate #(
   parameter int OPEN_THR     = 16,
   parameter int CLOSE_THR    = 8,
   parameter int HOLD_SAMPLES = 64
) (
   input logic                   clk,
   input logic                   rst,
   team_06_noise_gate_if.slave   bus
);

   localparam int CW = $clog2(HOLD_SAMPLES + 1);
   localparam logic [7:0]    OPEN_T   = 8'(OPEN_THR);
   localparam logic [7:0]    CLOSE_T  = 8'(CLOSE_THR);
   localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_SAMPLES);

   typedef enum logic [1:0] {CLOSED, OPEN, HOLD} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] hold_cnt, cnt_nxt;
   logic [7:0]    mag;
   logic          quiet;
   logic          pass;
   logic [7:0]    aud_nxt;
   logic          open_nxt;

`ifdef TEAM_06_NG_FADE_EN
   logic [3:0]         gain, gain_nxt;
   logic signed [8:0]  centred;
   logic signed [12:0] prod;
   logic signed [12:0] scaled;
`endif

   assign mag   = (bus.mic_aud >= 8'd128) ? (bus.mic_aud - 8'd128) : (8'd128 - bus.mic_aud);
   assign quiet = (mag < CLOSE_T);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = hold_cnt;
      if (!bus.gate_en) begin
         state_nxt = CLOSED;
         cnt_nxt   = '0;
      end else begin
         case (state)
            CLOSED: begin
               if (mag >= OPEN_T) state_nxt = OPEN;
            end
            OPEN: begin
               if (quiet) begin
                  state_nxt = HOLD;
                  cnt_nxt   = CW'(1);
               end
            end
            HOLD: begin
               if (!quiet) begin
                  state_nxt = OPEN;
                  cnt_nxt   = '0;
               end else if (hold_cnt < HOLD_MAX) begin
                  cnt_nxt   = hold_cnt + CW'(1);
               end else begin
                  state_nxt = CLOSED;
                  cnt_nxt   = '0;
               end
            end
            default: begin
               state_nxt = CLOSED;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   // The sample is passed whenever the gate will be open after this decision.
   assign pass = (state_nxt != CLOSED);

`ifdef TEAM_06_NG_FADE_EN
   always_comb begin
      gain_nxt = gain;
      if (!bus.gate_en)
         gain_nxt = 4'd8;
      else if (pass)
         gain_nxt = (gain >= 4'd8) ? 4'd8 : gain + 4'd1;
      else
         gain_nxt = (gain == 4'd0) ? 4'd0 : gain - 4'd1;
   end

   assign centred  = $signed({1'b0, bus.mic_aud}) - 9'sd128;
   assign prod     = 13'(centred) * 13'($signed({1'b0, gain_nxt}));
   assign scaled   = prod >>> 3;
   // scaled fits -128..127, so adding 128 in 8 bits recentres it without overflow.
   assign aud_nxt  = scaled[7:0] + 8'd128;
   assign open_nxt = (gain_nxt != 4'd0);
`else
   assign aud_nxt  = (!bus.gate_en || pass) ? bus.mic_aud : 8'd128;
   assign open_nxt = !bus.gate_en || pass;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= CLOSED;
         hold_cnt       <= '0;
         bus.gate_aud   <= 8'd128;
         bus.gate_valid <= 1'b0;
         bus.gate_open  <= 1'b0;
`ifdef TEAM_06_NG_FADE_EN
         gain           <= 4'd0;
`endif
      end else begin
         bus.gate_valid <= bus.samp_valid;
         if (bus.samp_valid) begin
            state         <= state_nxt;
            hold_cnt      <= cnt_nxt;
            bus.gate_aud  <= aud_nxt;
            bus.gate_open <= open_nxt;
`ifdef TEAM_06_NG_FADE_EN
            gain          <= gain_nxt;
`endif
         end
      end
   end

endmodule
